xip_line_cache: RTL and testbench

- Read-only, direct-mapped line cache between the CPU-side AHB bus and the AHB XIP flash controller.
- Serves hits with zero wait states.
- On a miss, refills a whole 32-byte line from the XIP controller as four single 64-bit reads, then returns the requested doubleword.
- Purpose: hides the multi-cycle QPI fetch latency for instruction and constant fetch.

---
 rtl/xip_line_cache.sv | 215 +++++++++++++++++++++
 tb/tb_xip_line_cache.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xip_line_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : xip_line_cache
// Purpose : Read-only direct-mapped 32-byte line cache in front of an AHB XIP
//           flash controller; hits are zero-wait, misses refill with 4 beats.
// Revision: 1.0
// ============================================================================
module xip_line_cache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        flush,
    input  logic        S_HSEL,
    input  logic [35:0] S_HADDR,
    input  logic        S_HWRITE,
    input  logic [1:0]  S_HTRANS,
    input  logic [2:0]  S_HSIZE,
    input  logic [2:0]  S_HBURST,
    input  logic [63:0] S_HWDATA,
    input  logic        S_HREADY,
    output logic        S_HREADYOUT,
    output logic        S_HRESP,
    output logic [63:0] S_HRDATA,
    output logic [35:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic [2:0]  M_HSIZE,
    output logic [2:0]  M_HBURST,
    output logic        M_HWRITE,
    input  logic        M_HREADY,
    input  logic [63:0] M_HRDATA,
    input  logic        M_HRESP
);

    localparam int IDX_W = $clog2(LINES);
    localparam int LA_W  = ADDR_W - 5;
    localparam int TAG_W = LA_W - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MADDR = 3'd1,
        ST_MDATA = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                active_q, active_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LA_W-1:0]     base_q, base_d;
    logic [1:0]          beat_q, beat_d;
    logic                poison_q, poison_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [TAG_W-1:0]    tag_d [LINES];
    logic [63:0]         data_q [LINES][4];
    logic [63:0]         data_d [LINES][4];

    logic                w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic [1:0]          w_off;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_rd_req;
    logic [IDX_W-1:0]    w_ridx;
    logic [TAG_W-1:0]    w_rtag;
    logic                unused_ok;

    assign w_accept = S_HSEL && S_HTRANS[1] && S_HREADY;
    assign w_idx    = addr_q[5 +: IDX_W];
    assign w_off    = addr_q[4:3];
    assign w_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign w_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_rd_req = (state_q == ST_IDLE) && active_q && !write_q;
    // Refill bookkeeping follows the latched line base, not the live address.
    assign w_ridx   = base_q[IDX_W-1:0];
    assign w_rtag   = base_q[LA_W-1 -: TAG_W];

    assign unused_ok = ^{S_HWDATA, S_HBURST, S_HSIZE, S_HTRANS[0],
                         S_HADDR[35:ADDR_W], addr_q[2:0]};

    assign M_HADDR  = {{(36-ADDR_W){1'b0}}, base_q, beat_q, 3'b000};
    assign M_HSIZE  = 3'b011;
    assign M_HBURST = 3'b000;
    assign M_HWRITE = 1'b0;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        write_d  = write_q;
        addr_d   = addr_q;
        base_d   = base_q;
        beat_d   = beat_q;
        poison_d = poison_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;

        if (S_HREADY) begin
            active_d = w_accept;
            if (w_accept) begin
                addr_d  = S_HADDR[ADDR_W-1:0];
                write_d = S_HWRITE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_rd_req && !w_hit) begin
                    state_d        = ST_MADDR;
                    beat_d         = 2'd0;
                    base_d         = addr_q[ADDR_W-1:5];
                    // The old line is overwritten beat by beat; never let it look valid.
                    valid_d[w_idx] = 1'b0;
                end
            end
            ST_MADDR: begin
                if (M_HREADY) state_d = ST_MDATA;
            end
            ST_MDATA: begin
                if (M_HRESP) begin
                    state_d  = ST_ERR1;
                    poison_d = 1'b0;
                end else if (M_HREADY) begin
                    data_d[w_ridx][beat_q] = M_HRDATA;
                    if (beat_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ST_MADDR;
                    end
                end
            end
            ST_DONE: begin
                if (!poison_q) begin
                    valid_d[w_ridx] = 1'b1;
                    tag_d[w_ridx]   = w_rtag;
                end
                poison_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Flush overrides everything above, including a DONE in the same cycle.
        if (flush) begin
            valid_d = '0;
            if ((state_q == ST_MADDR) || ((state_q == ST_MDATA) && !M_HRESP))
                poison_d = 1'b1;
        end
    end

    always_comb begin
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b0;
        S_HRDATA    = '0;
        M_HTRANS    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (w_rd_req) begin
                    if (w_hit) S_HRDATA = data_q[w_idx][w_off];
                    else       S_HREADYOUT = 1'b0;
                end
            end
            ST_MADDR: begin
                S_HREADYOUT = 1'b0;
                M_HTRANS    = 2'b10;
            end
            ST_MDATA: S_HREADYOUT = 1'b0;
            ST_DONE:  S_HRDATA = data_q[w_ridx][w_off];
            ST_ERR1: begin
                S_HREADYOUT = 1'b0;
                S_HRESP     = 1'b1;
            end
            ST_ERR2:  S_HRESP = 1'b1;
            default:  S_HREADYOUT = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            base_q   <= '0;
            beat_q   <= 2'd0;
            poison_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            poison_q <= poison_d;
            valid_q  <= valid_d;
        end
    end

    // Array contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge HCLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_xip_line_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_xip_line_cache
// Purpose : Directed self-checking bench with an XIP slave model and a
//           tag/valid cache model for xip_line_cache.
// Revision: 1.0
// ============================================================================
module tb_xip_line_cache;

    localparam int LINES = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        flush = 1'b0;
    logic        S_HSEL = 1'b0;
    logic [35:0] S_HADDR = '0;
    logic        S_HWRITE = 1'b0;
    logic [1:0]  S_HTRANS = 2'b00;
    logic [2:0]  S_HSIZE = 3'b011;
    logic [2:0]  S_HBURST = 3'b000;
    logic [63:0] S_HWDATA = '0;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic        S_HRESP;
    logic [63:0] S_HRDATA;
    logic [35:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HSIZE;
    logic [2:0]  M_HBURST;
    logic        M_HWRITE;
    logic        M_HREADY = 1'b1;
    logic [63:0] M_HRDATA = '0;
    logic        M_HRESP = 1'b0;

    assign S_HREADY = S_HREADYOUT;

    xip_line_cache #(.LINES(LINES), .ADDR_W(24)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .flush(flush),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE),
        .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HSIZE(M_HSIZE),
        .M_HBURST(M_HBURST), .M_HWRITE(M_HWRITE),
        .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
    );

    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    int          xwait = 0;
    bit          inj_en = 1'b0;
    logic [35:0] inj_addr = '0;
    logic [35:0] mon_q [$];
    logic [35:0] last_b [$];
    bit          busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] flash(input logic [35:0] a);
        return {8'hA5, a[23:0], 8'h5A, ~a[23:0]};
    endfunction

    function automatic bit m_hit(input logic [35:0] a);
        int unsigned ln;
        ln = a[23:0] / 32;
        return mvalid[ln % LINES] && (mtag[ln % LINES] == ln / LINES);
    endfunction

    function automatic void m_fill(input logic [35:0] a);
        int unsigned ln;
        ln = a[23:0] / 32;
        mvalid[ln % LINES] = 1'b1;
        mtag[ln % LINES]   = ln / LINES;
    endfunction

    function automatic void m_inval(input logic [35:0] a);
        int unsigned ln;
        ln = a[23:0] / 32;
        mvalid[ln % LINES] = 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endfunction

    // XIP controller model: single-beat AHB slave with wait states and an error hook.
    initial begin
        bit          dph;
        bit          derr;
        int          cnt;
        int          estep;
        logic [35:0] dad;
        logic [1:0]  s_tr;
        logic [35:0] s_ad;
        logic        s_rdy;
        dph = 0; derr = 0; cnt = 0; estep = 0; dad = '0;
        forever begin
            @(negedge HCLK);
            s_tr = M_HTRANS; s_ad = M_HADDR; s_rdy = M_HREADY;
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                dph = 0;
            end else begin
                if (dph && s_rdy) dph = 0;
                if (s_tr[1] && s_rdy) begin
                    dph = 1; dad = s_ad; cnt = xwait; estep = 0;
                    derr = inj_en && (s_ad == inj_addr);
                    if (derr) inj_en = 1'b0;
                    mon_q.push_back(s_ad);
                end
            end
            if (dph && derr) begin
                M_HRESP = 1'b1; M_HREADY = (estep != 0); estep++;
            end else if (dph && cnt > 0) begin
                M_HRESP = 1'b0; M_HREADY = 1'b0; cnt--;
            end else if (dph) begin
                M_HRESP = 1'b0; M_HREADY = 1'b1; M_HRDATA = flash(dad);
            end else begin
                M_HRESP = 1'b0; M_HREADY = 1'b1;
            end
        end
    end

    // Every-cycle compare: fixed master attributes, and an idle slave between transfers.
    initial begin
        bit bc;
        forever begin
            @(posedge HCLK);
            #2 bc = busy;
            @(negedge HCLK);
            if (HRESETn) begin
                chk("m_hsize", M_HSIZE, 3'b011);
                chk("m_hburst", M_HBURST, 3'b000);
                chk("m_hwrite", M_HWRITE, 1'b0);
                if (!bc) begin
                    chk("idle_hreadyout", S_HREADYOUT, 1'b1);
                    chk("idle_hresp", S_HRESP, 1'b0);
                    chk("idle_m_htrans", M_HTRANS, 2'b00);
                end
            end
        end
    end

    task automatic wait_rdy(input logic [35:0] fa, input bit fen,
                            output int waits, output bit err_lo, output bit fired);
        bit done;
        done = 0; waits = 0; err_lo = 0; fired = 0;
        while (!done) begin
            @(negedge HCLK);
            flush = 1'b0;
            if (fen && !fired && M_HTRANS == 2'b10 && M_HADDR == fa) begin
                flush = 1'b1;
                fired = 1;
            end
            if (S_HREADYOUT) begin
                done = 1;
            end else begin
                waits++;
                if (S_HRESP) err_lo = 1;
                if (waits > 300) begin
                    chk("hreadyout_timeout", 1'b0, 1'b1);
                    done = 1;
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic rd(input logic [35:0] a, input bit exp_err, input int fbeat,
                      output int lat, output logic [63:0] dat);
        bit          hit, elo, fired;
        logic [35:0] base, fa;
        int          nb;
        hit  = m_hit(a);
        base = {12'h0, a[23:5], 5'h00};
        fa   = (fbeat < 0) ? base : base + 36'(8 * fbeat);
        @(posedge HCLK);
        #1 busy = 1'b1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = a; S_HWRITE = 1'b0;
        @(posedge HCLK);
        #1 S_HSEL = 1'b0; S_HTRANS = 2'b00;
        wait_rdy(fa, fbeat >= 0, lat, elo, fired);
        dat = S_HRDATA;
        if (exp_err) begin
            chk("err_first_cycle", elo, 1'b1);
            chk("err_resp", S_HRESP, 1'b1);
            nb = int'((inj_addr - base) / 8) + 1;
        end else begin
            chk("rd_resp", S_HRESP, 1'b0);
            chk("rd_data", S_HRDATA, flash(a));
            chk("rd_latency", lat, hit ? 0 : 9 + 4 * xwait);
            nb = hit ? 0 : 4;
        end
        chk("beat_count", mon_q.size(), nb);
        for (int i = 0; i < mon_q.size() && i < nb; i++)
            chk("beat_addr", mon_q[i], base + 36'(8 * i));
        last_b = mon_q;
        mon_q.delete();
        if (fired) m_clear();
        if (!hit) begin
            m_inval(a);
            if (!exp_err && !fired) m_fill(a);
        end
        busy = 1'b0;
    endtask

    task automatic wr(input logic [35:0] a);
        @(posedge HCLK);
        #1 busy = 1'b1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = a; S_HWRITE = 1'b1;
        @(posedge HCLK);
        #1 S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0;
        S_HWDATA = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge HCLK);
        chk("wr_hreadyout", S_HREADYOUT, 1'b1);
        chk("wr_hresp", S_HRESP, 1'b0);
        @(negedge HCLK);
        chk("wr_beats", mon_q.size(), 0);
        busy = 1'b0;
    endtask

    task automatic flush_idle();
        @(posedge HCLK);
        #1 flush = 1'b1;
        @(posedge HCLK);
        #1 flush = 1'b0;
        m_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n;
        logic [63:0] dat;
        bit          elo, fired;
        m_clear();
        for (int i = 0; i < LINES; i++) mtag[i] = 0;

        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_hreadyout", S_HREADYOUT, 1'b1);
        chk("rst_hresp", S_HRESP, 1'b0);
        chk("rst_hrdata", S_HRDATA, 64'h0);
        chk("rst_m_htrans", M_HTRANS, 2'b00);
        chk("rst_m_haddr", M_HADDR, 36'h0);

        // Cold miss, pinned with literals.
        rd(36'h000108, 0, -1, lat, dat);
        chk("cold_lat", lat, 9);
        chk("cold_data", dat, 64'hA500_0108_5AFF_FEF7);
        chk("cold_b0", last_b[0], 36'h100);
        chk("cold_b1", last_b[1], 36'h108);
        chk("cold_b2", last_b[2], 36'h110);
        chk("cold_b3", last_b[3], 36'h118);

        rd(36'h000118, 0, -1, lat, dat);
        chk("hit_lat", lat, 0);
        chk("hit_data", dat, 64'hA500_0118_5AFF_FEE7);

        // Conflict on index 8.
        rd(36'h000100, 0, -1, lat, dat);
        rd(36'h000300, 0, -1, lat, dat);
        rd(36'h000100, 0, -1, lat, dat);
        chk("conflict_refill_lat", lat, 9);

        wr(36'h000100);
        rd(36'h000100, 0, -1, lat, dat);
        chk("after_write_hit_lat", lat, 0);

        // Error on beat 2.
        inj_addr = 36'h000210;
        inj_en   = 1'b1;
        rd(36'h000208, 1, -1, lat, dat);
        chk("err_beats_literal", last_b.size(), 3);
        rd(36'h000208, 0, -1, lat, dat);
        chk("after_err_miss_lat", lat, 9);

        // Flush during beat 1 of a refill.
        rd(36'h000408, 0, 1, lat, dat);
        chk("poison_data", dat, 64'hA500_0408_5AFF_FBF7);
        rd(36'h000408, 0, -1, lat, dat);
        chk("after_poison_miss_lat", lat, 9);
        rd(36'h000100, 0, -1, lat, dat);

        // Flush in idle.
        rd(36'h000108, 0, -1, lat, dat);
        flush_idle();
        rd(36'h000108, 0, -1, lat, dat);
        chk("after_flush_miss_lat", lat, 9);

        // XIP wait states.
        xwait = 2;
        rd(36'h000508, 0, -1, lat, dat);
        chk("waitstate_lat", lat, 17);
        xwait = 0;

        // Back-to-back: second address phase accepted in DONE.
        @(posedge HCLK);
        #1 busy = 1'b1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 36'h000708; S_HWRITE = 1'b0;
        @(posedge HCLK);
        #1 S_HADDR = 36'h000718;
        wait_rdy(36'h0, 1'b0, lat, elo, fired);
        chk("b2b_first_lat", lat, 9);
        chk("b2b_first_data", S_HRDATA, flash(36'h000708));
        @(posedge HCLK);
        #1 S_HSEL = 1'b0; S_HTRANS = 2'b00;
        @(negedge HCLK);
        chk("b2b_second_ready", S_HREADYOUT, 1'b1);
        chk("b2b_second_data", S_HRDATA, flash(36'h000718));
        chk("b2b_beats", mon_q.size(), 4);
        mon_q.delete();
        m_fill(36'h000708);
        busy = 1'b0;

        // Asynchronous reset in the middle of a refill data phase.
        xwait = 3;
        @(posedge HCLK);
        #1 busy = 1'b1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 36'h000608;
        @(posedge HCLK);
        #1 S_HSEL = 1'b0; S_HTRANS = 2'b00;
        n = 0;
        while (!(mon_q.size() == 2 && M_HTRANS == 2'b00) && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("reach_mdata", n < 100, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_hreadyout", S_HREADYOUT, 1'b1);
        chk("arst_hresp", S_HRESP, 1'b0);
        chk("arst_hrdata", S_HRDATA, 64'h0);
        chk("arst_m_htrans", M_HTRANS, 2'b00);
        chk("arst_m_haddr", M_HADDR, 36'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        xwait = 0;
        mon_q.delete();
        m_clear();
        busy = 1'b0;
        rd(36'h000100, 0, -1, lat, dat);
        chk("post_reset_miss_lat", lat, 9);
        rd(36'h000608, 0, -1, lat, dat);

        repeat (3) @(posedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
